// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S master receiver; divides CLK into sck/ws and deserializes NUM_MICS stereo sd lines.
// Define I2S_RX_HOLD_EN for a sample_valid that holds until sample_ack, plus a sticky overrun flag.
module i2s_mic_rx #(
    parameter int NUM_MICS    = 4,
    parameter int SAMPLE_BITS = 18,
    parameter int SLOT_BITS   = 32,
    parameter int SCK_DIV     = 16
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            ENABLE,
    input  logic [NUM_MICS-1:0]             sd,
`ifdef I2S_RX_HOLD_EN
    input  logic                            sample_ack,
    output logic                            overrun,
`endif
    output logic                            sck,
    output logic                            ws,
    output logic [NUM_MICS*SAMPLE_BITS-1:0] data_left,
    output logic [NUM_MICS*SAMPLE_BITS-1:0] data_right,
    output logic                            sample_valid,
    output logic [15:0]                     frame_count
);
    localparam int DW = $clog2(SCK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int PW = NUM_MICS * SAMPLE_BITS;

    logic [DW-1:0]       div_cnt;
    logic [BW-1:0]       bit_cnt, bit_next;
    logic [NUM_MICS-1:0] sd_meta, sd_sync;
    logic [PW-1:0]       shift_l, shift_r, next_l, next_r;
    logic                primed, div_wrap, fall, frame_end, publish, cap_l, cap_r;

    // the last CLK of the sck high phase is both the sample point and the sck fall
    always_comb begin
        div_wrap  = div_cnt == DW'(SCK_DIV - 1);
        fall      = ENABLE & sck & div_wrap;
        frame_end = fall && bit_cnt == BW'(2 * SLOT_BITS - 1);
        publish   = frame_end & primed;
        bit_next  = frame_end ? '0 : bit_cnt + 1'b1;
        cap_l     = fall && bit_cnt >= BW'(1) && bit_cnt <= BW'(SAMPLE_BITS);
        cap_r     = fall && bit_cnt >= BW'(SLOT_BITS + 1) && bit_cnt <= BW'(SLOT_BITS + SAMPLE_BITS);
    end

    always_comb begin
        next_l = shift_l;
        next_r = shift_r;
        for (int i = 0; i < NUM_MICS; i++) begin
            next_l[i*SAMPLE_BITS +: SAMPLE_BITS] = cap_l ?
                {shift_l[i*SAMPLE_BITS +: SAMPLE_BITS-1], sd_sync[i]} : shift_l[i*SAMPLE_BITS +: SAMPLE_BITS];
            next_r[i*SAMPLE_BITS +: SAMPLE_BITS] = cap_r ?
                {shift_r[i*SAMPLE_BITS +: SAMPLE_BITS-1], sd_sync[i]} : shift_r[i*SAMPLE_BITS +: SAMPLE_BITS];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sd_meta <= '0;
            sd_sync <= '0;
        end else begin
            sd_meta <= sd;
            sd_sync <= sd_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            shift_l <= '0;
            shift_r <= '0;
            primed  <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            sck     <= sck ^ div_wrap;
            if (fall) begin
                bit_cnt <= bit_next;
                ws      <= bit_next >= BW'(SLOT_BITS);
            end
            shift_l <= next_l;
            shift_r <= next_r;
            primed  <= primed | frame_end;
        end
    end

    // publish takes the combinational next shift value so a capture on the final period is included
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_left    <= '0;
            data_right   <= '0;
            frame_count  <= '0;
            sample_valid <= 1'b0;
`ifdef I2S_RX_HOLD_EN
            overrun      <= 1'b0;
`endif
        end else begin
            if (publish) begin
                data_left   <= next_l;
                data_right  <= next_r;
                frame_count <= frame_count + 16'd1;
            end
`ifdef I2S_RX_HOLD_EN
            sample_valid <= publish | (sample_valid & ~sample_ack);
            overrun      <= overrun | (publish & sample_valid & ~sample_ack);
`else
            sample_valid <= publish;
`endif
        end
    end
endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: table-driven bench for i2s_mic_rx with a behavioural I2S microphone array.
// Also exercises the I2S_RX_HOLD_EN variant when that macro is defined.
module tb_i2s_mic_rx;
    localparam int NM = 4, SB = 18, SL = 32, SD = 4, F = 4 * SD * SL, N = 12;

    logic             clk = 1'b0, RESET = 1'b1, ENABLE = 1'b0;
    logic [NM-1:0]    sd = '0;
    logic             sck, ws, sample_valid;
    logic [NM*SB-1:0] data_left, data_right;
    logic [15:0]      frame_count;
`ifdef I2S_RX_HOLD_EN
    logic             sample_ack = 1'b1;
    logic             overrun;
`endif

    always #5 clk = ~clk;

    i2s_mic_rx #(.NUM_MICS(NM), .SAMPLE_BITS(SB), .SLOT_BITS(SL), .SCK_DIV(SD)) dut (
        .CLK(clk), .RESET(RESET), .ENABLE(ENABLE), .sd(sd),
`ifdef I2S_RX_HOLD_EN
        .sample_ack(sample_ack), .overrun(overrun),
`endif
        .sck(sck), .ws(ws), .data_left(data_left), .data_right(data_right),
        .sample_valid(sample_valid), .frame_count(frame_count)
    );

    typedef struct packed {
        logic [NM-1:0][SB-1:0] l;
        logic [NM-1:0][SB-1:0] r;
        logic [NM*SB-1:0]      exp_l;
        logic [NM*SB-1:0]      exp_r;
        logic [15:0]           exp_cnt;
    } vec_t;

    vec_t tbl [N];
    int   compared = 0, mismatched = 0, cyc = 0, t0 = 0;
    int   mp = 0, fidx = 0;
    bit   running = 1'b0;
    logic psck = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc - t0 < c) @(negedge clk);
    endtask

    // I2S word: sample MSB-first after a one-period delay, filler bits driven 1
    function automatic logic mic_bit(input int f, input int m, input int p);
        logic [SL-1:0] lw, rw;
        if (f >= N) begin
            lw = $urandom;
            rw = $urandom;
        end else begin
            lw = {tbl[f].l[m], {(SL-SB){1'b1}}};
            rw = {tbl[f].r[m], {(SL-SB){1'b1}}};
        end
        if (p == 0 || p == SL) return 1'b1;
        return p < SL ? lw[SL-p] : rw[2*SL-p];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (RESET || !ENABLE) begin
                if (running) fidx++;
                running = 1'b0;
                mp = 0;
            end else begin
                running = 1'b1;
                if (psck && !sck) begin
                    mp = (mp == 2 * SL - 1) ? 0 : mp + 1;
                    if (mp == 0) fidx++;
                end
            end
            psck = sck;
            for (int m = 0; m < NM; m++) sd[m] = mic_bit(fidx, m, mp);
        end
    end

    initial begin
        int early, w;
        logic [15:0] top;
        top = 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            if (i < 2) begin
                tbl[i].l = {18'h00001, 18'h1FFFF, 18'h20000, 18'h2A5A5};
                tbl[i].r = {18'h00001, 18'h1FFFF, 18'h20000, 18'h15A5A};
            end else begin
                for (int m = 0; m < NM; m++) begin
                    tbl[i].l[m] = 18'($urandom);
                    tbl[i].r[m] = 18'($urandom);
                end
            end
            tbl[i].exp_l = '0;
            tbl[i].exp_r = '0;
            for (int m = 0; m < NM; m++) begin
                tbl[i].exp_l = tbl[i].exp_l + ((NM*SB)'(tbl[i].l[m]) << (m * SB));
                tbl[i].exp_r = tbl[i].exp_r + ((NM*SB)'(tbl[i].r[m]) << (m * SB));
            end
            tbl[i].exp_cnt = (i == 1) ? 16'd1 : (i == N - 1) ? top + 16'd1 : 16'(i - 2);
        end

        repeat (4) @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_ws", ws, 0);
        chk("rst_left", data_left, 0);
        chk("rst_right", data_right, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_count", frame_count, 0);
`ifdef I2S_RX_HOLD_EN
        chk("rst_overrun", overrun, 0);
`endif
        RESET = 1'b0;
        ENABLE = 1'b1;
        t0 = cyc;
        at(3);   chk("sck_c3", sck, 0);
        at(4);   chk("sck_rise_c4", sck, 1);
        at(7);   chk("sck_c7", sck, 1);
        at(8);   chk("sck_fall_c8", sck, 0);
        at(255); chk("ws_c255", ws, 0);
        at(256); chk("ws_rise_c256", ws, 1);
        early = 0;
        while (cyc - t0 < 1024) begin
            if (sample_valid) early++;
            @(negedge clk);
        end
        chk("no_valid_first_frame", early, 0);
        chk("valid_c1024", sample_valid, 1);
        chk("left_c1024", data_left, tbl[1].exp_l);
        chk("right_c1024", data_right, tbl[1].exp_r);
        chk("count_c1024", frame_count, tbl[1].exp_cnt);
        at(1025); chk("valid_pulse_c1025", sample_valid, 0);

        at(1300);
        ENABLE = 1'b0;
        at(1301);
        chk("dis_sck", sck, 0);
        chk("dis_ws", ws, 0);
        early = 0;
        while (cyc - t0 < 1310) begin
            if (sample_valid) early++;
            @(negedge clk);
        end
        chk("dis_no_valid", early, 0);
        chk("dis_left_hold", data_left, tbl[1].exp_l);
        chk("dis_right_hold", data_right, tbl[1].exp_r);
        chk("dis_count_hold", frame_count, 16'd1);
        ENABLE = 1'b1;
        t0 = cyc;

        for (int i = 4; i < N; i++) begin
            w = 0;
            while (!sample_valid && w < 2 * F) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("valid_time_%0d", i), cyc - t0, 512 * (i - 2));
            chk($sformatf("left_%0d", i), data_left, tbl[i].exp_l);
            chk($sformatf("right_%0d", i), data_right, tbl[i].exp_r);
            chk($sformatf("count_%0d", i), frame_count, tbl[i].exp_cnt);
            @(negedge clk);
            chk($sformatf("pulse_%0d", i), sample_valid, 0);
            if (i == N - 2) begin
                force dut.frame_count = 16'hFFFF;
                @(negedge clk);
                release dut.frame_count;
            end
        end

`ifdef I2S_RX_HOLD_EN
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        sample_ack = 1'b0;
        t0 = cyc;
        at(1024); chk("hold_valid_1", sample_valid, 1);
        chk("hold_overrun_1", overrun, 0);
        at(1100); chk("hold_valid_held", sample_valid, 1);
        at(1535); sample_ack = 1'b1;
        at(1536); sample_ack = 1'b0;
        chk("hold_ack_on_publish_valid", sample_valid, 1);
        chk("hold_ack_on_publish_overrun", overrun, 0);
        at(2048); chk("hold_valid_3", sample_valid, 1);
        chk("hold_overrun_set", overrun, 1);
        at(2100); sample_ack = 1'b1;
        at(2101); sample_ack = 1'b0;
        chk("hold_ack_clears", sample_valid, 0);
        chk("hold_overrun_sticky", overrun, 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
